// File: rtl/debug_pack.sv
// Shared constants for the JTAG debug transport: IR codes, DMI op/status
// encodings, DTMCS field layout and the TAP/DMI state encodings.
package debug_pack;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE, OP_RSVD} dmi_op_e;
    typedef enum logic [1:0] {ST_OK, ST_RSVD, ST_FAILED, ST_BUSY} dmistat_e;

    localparam int DTMCS_VER_LSB   = 0;
    localparam int DTMCS_ABITS_LSB = 4;
    localparam int DTMCS_STAT_LSB  = 10;
    localparam int DTMCS_IDLE_LSB  = 12;
    localparam int DTMCS_DMIRESET  = 16;
    localparam int DTMCS_HARDRESET = 17;
    localparam logic [3:0] DTM_VERSION = 4'd1;

    localparam logic [3:0] TAP_TLR     = 4'd0;
    localparam logic [3:0] TAP_RTI     = 4'd1;
    localparam logic [3:0] TAP_SELDR   = 4'd2;
    localparam logic [3:0] TAP_CAPDR   = 4'd3;
    localparam logic [3:0] TAP_SHDR    = 4'd4;
    localparam logic [3:0] TAP_EX1DR   = 4'd5;
    localparam logic [3:0] TAP_PAUSEDR = 4'd6;
    localparam logic [3:0] TAP_EX2DR   = 4'd7;
    localparam logic [3:0] TAP_UPDDR   = 4'd8;
    localparam logic [3:0] TAP_SELIR   = 4'd9;
    localparam logic [3:0] TAP_CAPIR   = 4'd10;
    localparam logic [3:0] TAP_SHIR    = 4'd11;
    localparam logic [3:0] TAP_EX1IR   = 4'd12;
    localparam logic [3:0] TAP_PAUSEIR = 4'd13;
    localparam logic [3:0] TAP_EX2IR   = 4'd14;
    localparam logic [3:0] TAP_UPDIR   = 4'd15;

    localparam logic [1:0] D_IDLE  = 2'd0;
    localparam logic [1:0] D_REQ   = 2'd1;
    localparam logic [1:0] D_RSP   = 2'd2;
    localparam logic [1:0] D_DRAIN = 2'd3;

endpackage

// File: rtl/dtm_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine; state advances on posedge tclk.
module dtm_tap_fsm
    import debug_pack::*;
(
    input  logic       tclk,
    input  logic       trst,
    input  logic       tms,
    output logic [3:0] state
);

    logic [3:0] nxt;

    always_comb begin
        nxt = TAP_TLR;
        case (state)
            TAP_TLR:     nxt = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:     nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR:   nxt = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR:   nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:    nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR:   nxt = tms ? TAP_UPDDR : TAP_PAUSEDR;
            TAP_PAUSEDR: nxt = tms ? TAP_EX2DR : TAP_PAUSEDR;
            TAP_EX2DR:   nxt = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR:   nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR:   nxt = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR:   nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:    nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR:   nxt = tms ? TAP_UPDIR : TAP_PAUSEIR;
            TAP_PAUSEIR: nxt = tms ? TAP_EX2IR : TAP_PAUSEIR;
            TAP_EX2IR:   nxt = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR:   nxt = tms ? TAP_SELDR : TAP_RTI;
            default:     nxt = TAP_TLR;
        endcase
    end

    always_ff @(posedge tclk or posedge trst) begin
        if (trst) state <= TAP_TLR;
        else      state <= nxt;
    end

endmodule

// File: rtl/dtm_jtag_dmi.sv
// JTAG debug transport module: TAP, IDCODE/DTMCS/DMI/BYPASS data registers and
// the DMI request/response handshake. Optional DTM_DMI_TIMEOUT_EN adds a response timeout.
module dtm_jtag_dmi
    import debug_pack::*;
#(
    parameter int          IR_WIDTH    = 5,
    parameter int          ABITS       = 7,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
    parameter int          IDLE_HINT   = 1,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic             tclk,
    input  logic             trst,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    output logic             dmi_req_vld,
    input  logic             dmi_req_rdy,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_rsp_vld,
    output logic             dmi_rsp_rdy,
    input  logic [31:0]      dmi_rsp_data,
    input  logic [1:0]       dmi_rsp_op
);

    localparam int DR_W = ABITS + 34;

    if (IR_WIDTH < 5 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("dtm_jtag_dmi: IR_WIDTH must be >= 5 and TIMEOUT_CYC >= 1");
    end

    logic [3:0]          tap_st;
    logic [IR_WIDTH-1:0] ir, ir_sr;
    logic [DR_W-1:0]     dr_sr, dr_shf, dr_cap;
    logic [31:0]         dtmcs;
    int                  dr_len;
    logic [1:0]          dmi_st;
    dmistat_e            sticky;
    logic [ABITS-1:0]    last_addr;
    logic [31:0]         rsp_hold;

    dtm_tap_fsm u_tap (.tclk(tclk), .trst(trst), .tms(tms), .state(tap_st));

    wire sel_idcode = (ir == IR_WIDTH'(IR_IDCODE));
    wire sel_dtmcs  = (ir == IR_WIDTH'(IR_DTMCS));
    wire sel_dmi    = (ir == IR_WIDTH'(IR_DMI));
    wire busy       = (dmi_st == D_REQ) || (dmi_st == D_RSP);
    wire cap_dmi    = (tap_st == TAP_CAPDR) && sel_dmi;
    wire upd_dmi    = (tap_st == TAP_UPDDR) && sel_dmi;
    wire upd_dtmcs  = (tap_st == TAP_UPDDR) && sel_dtmcs;
    wire soft_rst   = upd_dtmcs && dr_sr[DTMCS_DMIRESET];
    wire hard_rst   = upd_dtmcs && dr_sr[DTMCS_HARDRESET];

    wire [1:0]       sh_op   = dr_sr[1:0];
    wire [31:0]      sh_data = dr_sr[33:2];
    wire [ABITS-1:0] sh_addr = dr_sr[DR_W-1:34];

    always_comb begin
        dtmcs = '0;
        dtmcs[DTMCS_VER_LSB +: 4]   = DTM_VERSION;
        dtmcs[DTMCS_ABITS_LSB +: 6] = 6'(ABITS);
        dtmcs[DTMCS_STAT_LSB +: 2]  = sticky;
        dtmcs[DTMCS_IDLE_LSB +: 3]  = 3'(IDLE_HINT);
        dr_cap = '0;
        dr_len = 1;
        if (sel_idcode) begin
            dr_cap = DR_W'(IDCODE_VAL);
            dr_len = 32;
        end else if (sel_dtmcs) begin
            dr_cap = DR_W'(dtmcs);
            dr_len = 32;
        end else if (sel_dmi) begin
            dr_cap = {last_addr, rsp_hold, busy ? ST_BUSY : sticky};
            dr_len = DR_W;
        end
    end

    // tdi enters at the top of the selected register, so each length shifts in place
    always_comb begin
        logic [DR_W-1:0] down;
        down   = dr_sr >> 1;
        dr_shf = '0;
        for (int i = 0; i < DR_W; i++) begin
            if (i == dr_len - 1)    dr_shf[i] = tdi;
            else if (i < dr_len - 1) dr_shf[i] = down[i];
        end
    end

    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            ir    <= IR_WIDTH'(IR_IDCODE);
            ir_sr <= '0;
            dr_sr <= '0;
        end else begin
            case (tap_st)
                TAP_TLR:   ir    <= IR_WIDTH'(IR_IDCODE);
                TAP_CAPIR: ir_sr <= IR_WIDTH'(1);
                TAP_SHIR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
                TAP_UPDIR: ir    <= ir_sr;
                TAP_CAPDR: dr_sr <= dr_cap;
                TAP_SHDR:  dr_sr <= dr_shf;
                default: ;
            endcase
        end
    end

`ifdef DTM_DMI_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge tclk or posedge trst) begin
        if (trst)                               tmo_cnt <= '0;
        else if (dmi_st == D_RSP && !dmi_rsp_vld) tmo_cnt <= tmo_cnt + 1'b1;
        else                                    tmo_cnt <= '0;
    end
`endif

    always_ff @(posedge tclk or posedge trst) begin
        if (trst) begin
            dmi_st       <= D_IDLE;
            sticky       <= ST_OK;
            last_addr    <= '0;
            rsp_hold     <= '0;
            dmi_req_addr <= '0;
            dmi_req_data <= '0;
            dmi_req_op   <= '0;
        end else begin
            case (dmi_st)
                D_IDLE: if (upd_dmi && sticky == ST_OK && (sh_op == OP_READ || sh_op == OP_WRITE)) begin
                    dmi_st       <= D_REQ;
                    dmi_req_addr <= sh_addr;
                    dmi_req_data <= sh_data;
                    dmi_req_op   <= sh_op;
                    last_addr    <= sh_addr;
                end
                // An abort coinciding with acceptance still owes a response, so drain it
                D_REQ: if (hard_rst)        dmi_st <= dmi_req_rdy ? D_DRAIN : D_IDLE;
                       else if (dmi_req_rdy) dmi_st <= D_RSP;
                D_RSP: if (dmi_rsp_vld) begin
                    dmi_st <= D_IDLE;
                    if (!hard_rst) begin
                        rsp_hold <= dmi_rsp_data;
                        if (dmi_rsp_op == 2'd2)      sticky <= ST_FAILED;
                        else if (dmi_rsp_op == 2'd3) sticky <= ST_BUSY;
                    end
                end else if (hard_rst) begin
                    dmi_st <= D_DRAIN;
                end
`ifdef DTM_DMI_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    dmi_st <= D_DRAIN;
                    sticky <= ST_FAILED;
                end
`endif
                default: if (dmi_rsp_vld) dmi_st <= D_IDLE;
            endcase
            if (cap_dmi && busy) sticky <= ST_BUSY;
            if (upd_dmi && sticky == ST_OK && dmi_st != D_IDLE) sticky <= ST_BUSY;
            if (soft_rst || hard_rst) sticky <= ST_OK;
        end
    end

    assign dmi_req_vld = (dmi_st == D_REQ);
    assign dmi_rsp_rdy = (dmi_st == D_RSP) || (dmi_st == D_DRAIN);

    always_ff @(negedge tclk or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (tap_st == TAP_SHIR) begin
            tdo    <= ir_sr[0];
            tdo_en <= 1'b1;
        end else if (tap_st == TAP_SHDR) begin
            tdo    <= dr_sr[0];
            tdo_en <= 1'b1;
        end else begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dtm_jtag_dmi.sv
// Directed bench for dtm_jtag_dmi: drives JTAG from one initial block and a
// simple DMI slave model whose readiness and response are set by the stimulus.
module tb_dtm_jtag_dmi;

    logic        tclk = 1'b0;
    logic        trst = 1'b0;
    logic        tms = 1'b1;
    logic        tdi = 1'b0;
    logic        tdo, tdo_en;
    logic        dmi_req_vld;
    logic        dmi_req_rdy = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_rsp_vld = 1'b0;
    logic        dmi_rsp_rdy;
    logic [31:0] dmi_rsp_data = '0;
    logic [1:0]  dmi_rsp_op = '0;

    int checks = 0;
    int errors = 0;

    int          slv_rdy_dly = 0;
    logic        slv_rsp_en = 1'b0;
    logic [31:0] slv_rsp_data = '0;
    logic [1:0]  slv_rsp_op = '0;
    int          rdy_wait = 0;
    int          req_hs = 0;
    int          rsp_hs = 0;
    logic [6:0]  seen_addr = '0;
    logic [31:0] seen_data = '0;
    logic [1:0]  seen_op = '0;
    logic        unstable = 1'b0;
    logic        pend_vld = 1'b0;
    logic [40:0] pend_pl = '0;

    dtm_jtag_dmi #(
        .IR_WIDTH(5), .ABITS(7), .IDCODE_VAL(32'h1000_0001),
        .IDLE_HINT(1), .TIMEOUT_CYC(16)
    ) dut (
        .tclk(tclk), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .dmi_req_vld(dmi_req_vld), .dmi_req_rdy(dmi_req_rdy), .dmi_req_addr(dmi_req_addr),
        .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op), .dmi_rsp_vld(dmi_rsp_vld),
        .dmi_rsp_rdy(dmi_rsp_rdy), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
    );

    always #5 tclk = ~tclk;

    // Handshake monitor: counts accepted requests/responses, checks payload hold
    always @(posedge tclk) begin
        if (dmi_req_vld && dmi_req_rdy) begin
            req_hs    <= req_hs + 1;
            seen_addr <= dmi_req_addr;
            seen_data <= dmi_req_data;
            seen_op   <= dmi_req_op;
        end
        if (dmi_rsp_vld && dmi_rsp_rdy) rsp_hs <= rsp_hs + 1;
        if (dmi_req_vld && pend_vld && {dmi_req_addr, dmi_req_data, dmi_req_op} != pend_pl)
            unstable <= 1'b1;
        pend_vld <= dmi_req_vld && !dmi_req_rdy;
        pend_pl  <= {dmi_req_addr, dmi_req_data, dmi_req_op};
    end

    // Slave: ready after slv_rdy_dly cycles of valid; answers when slv_rsp_en
    always @(negedge tclk) begin
        if (dmi_req_vld && rdy_wait < slv_rdy_dly) begin
            rdy_wait    <= rdy_wait + 1;
            dmi_req_rdy <= 1'b0;
        end else if (dmi_req_vld) begin
            dmi_req_rdy <= 1'b1;
        end else begin
            dmi_req_rdy <= 1'b0;
            rdy_wait    <= 0;
        end
        if (req_hs > rsp_hs && slv_rsp_en) begin
            dmi_rsp_vld  <= 1'b1;
            dmi_rsp_data <= slv_rsp_data;
            dmi_rsp_op   <= slv_rsp_op;
        end else begin
            dmi_rsp_vld <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk_tap(input logic m, input logic d, output logic o);
        @(negedge tclk);
        #1;
        o   = tdo;
        tms = m;
        tdi = d;
    endtask

    task automatic idle(input int n);
        logic b;
        repeat (n) clk_tap(1'b0, 1'b0, b);
    endtask

    task automatic shift_ir(input logic [4:0] v, output logic [4:0] o);
        logic b;
        clk_tap(1'b1, 1'b0, b);
        clk_tap(1'b1, 1'b0, b);
        clk_tap(1'b0, 1'b0, b);
        clk_tap(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            clk_tap(i == 4, v[i], b);
            o[i] = b;
        end
        clk_tap(1'b1, 1'b0, b);
        clk_tap(1'b0, 1'b0, b);
    endtask

    task automatic shift_dr(input logic [63:0] v, input int len, output logic [63:0] o,
                            output logic en_all);
        logic b;
        o = '0;
        en_all = 1'b1;
        clk_tap(1'b1, 1'b0, b);
        clk_tap(1'b0, 1'b0, b);
        clk_tap(1'b0, 1'b0, b);
        for (int i = 0; i < len; i++) begin
            clk_tap(i == len - 1, v[i], b);
            o[i] = b;
            en_all = en_all & tdo_en;
        end
        clk_tap(1'b1, 1'b0, b);
        clk_tap(1'b0, 1'b0, b);
    endtask

    task automatic wait_req(input int n, input string tag);
        int k = 0;
        while (req_hs < n && k < 200) begin idle(1); k++; end
        chk(tag, 64'(req_hs >= n), 64'd1);
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int k = 0;
        while (rsp_hs < n && k < 200) begin idle(1); k++; end
        chk(tag, 64'(rsp_hs >= n), 64'd1);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return 64'({a, d, op});
    endfunction

    initial begin
        logic [63:0] dout;
        logic [4:0]  iout;
        logic        en;

        #1 trst = 1'b1;
        #20;
        chk("rst_tdo", 64'(tdo), 64'd0);
        chk("rst_tdo_en", 64'(tdo_en), 64'd0);
        chk("rst_req_vld", 64'(dmi_req_vld), 64'd0);
        chk("rst_rsp_rdy", 64'(dmi_rsp_rdy), 64'd0);
        @(negedge tclk);
        #2 trst = 1'b0;

        idle(1);
        chk("rti_tdo_en", 64'(tdo_en), 64'd0);
        shift_dr(64'd0, 32, dout, en);
        chk("idcode", dout, 64'h1000_0001);
        chk("idcode_tdo_en", 64'(en), 64'd1);

        shift_ir(5'h10, iout);
        chk("ir_capture", 64'(iout), 64'd1);
        shift_dr(64'd0, 32, dout, en);
        chk("dtmcs", dout, 64'h0000_1071);

        // write through DMI, slave ready after 3 cycles, ok response
        shift_ir(5'h11, iout);
        slv_rdy_dly  = 3;
        slv_rsp_en   = 1'b1;
        slv_rsp_op   = 2'd0;
        slv_rsp_data = 32'h0000_0055;
        shift_dr(dmi_word(7'h10, 32'hDEADBEEF, 2'd2), 41, dout, en);
        chk("dmi_cap_reset", dout, 64'd0);
        wait_rsp(1, "wr_rsp_done");
        chk("wr_req_count", 64'(req_hs), 64'd1);
        chk("wr_addr", 64'(seen_addr), 64'h10);
        chk("wr_data", 64'(seen_data), 64'hDEADBEEF);
        chk("wr_op", 64'(seen_op), 64'd2);
        chk("wr_stable", 64'(unstable), 64'd0);
        shift_dr(64'd0, 41, dout, en);
        chk("wr_after_cap", dout, dmi_word(7'h10, 32'h55, 2'd0));
        idle(3);
        chk("nop_no_req", 64'(req_hs), 64'd1);

        // read with response held off: busy capture makes status sticky
        slv_rdy_dly = 0;
        slv_rsp_en  = 1'b0;
        shift_dr(dmi_word(7'h04, 32'h0, 2'd1), 41, dout, en);
        wait_req(2, "rd_req_done");
        shift_dr(64'd0, 41, dout, en);
        chk("rd_busy_cap", dout, dmi_word(7'h04, 32'h55, 2'd3));
        slv_rsp_data = 32'hA5A5_0004;
        slv_rsp_en   = 1'b1;
        wait_rsp(2, "rd_rsp_done");
        shift_dr(64'd0, 41, dout, en);
        chk("rd_sticky_cap", dout, dmi_word(7'h04, 32'hA5A5_0004, 2'd3));
        chk("sticky_blocks_req", 64'(req_hs), 64'd2);
        shift_ir(5'h10, iout);
        shift_dr(64'h0001_0000, 32, dout, en);
        chk("dtmcs_busy", dout, 64'h0000_1C71);
        shift_ir(5'h11, iout);
        shift_dr(64'd0, 41, dout, en);
        chk("dmireset_cap", dout, dmi_word(7'h04, 32'hA5A5_0004, 2'd0));

        // hard reset with a read outstanding: late response is drained and dropped
        slv_rsp_en = 1'b0;
        shift_dr(dmi_word(7'h08, 32'h0, 2'd1), 41, dout, en);
        wait_req(3, "hr_req_done");
        shift_ir(5'h10, iout);
        shift_dr(64'h0002_0000, 32, dout, en);
        chk("hr_dtmcs", dout, 64'h0000_1071);
        idle(2);
        chk("drain_rsp_rdy", 64'(dmi_rsp_rdy), 64'd1);
        chk("drain_req_vld", 64'(dmi_req_vld), 64'd0);
        slv_rsp_data = 32'h0000_1234;
        slv_rsp_en   = 1'b1;
        wait_rsp(3, "drain_done");
        idle(1);
        slv_rsp_data = 32'hCAFE_0008;
        shift_ir(5'h11, iout);
        shift_dr(64'd0, 41, dout, en);
        chk("drain_discard", dout, dmi_word(7'h08, 32'hA5A5_0004, 2'd0));
        shift_dr(dmi_word(7'h0C, 32'h0, 2'd1), 41, dout, en);
        wait_rsp(4, "rd2_rsp_done");
        shift_dr(64'd0, 41, dout, en);
        chk("rd2_cap", dout, dmi_word(7'h0C, 32'hCAFE_0008, 2'd0));

`ifdef DTM_DMI_TIMEOUT_EN
        slv_rsp_en = 1'b0;
        shift_dr(dmi_word(7'h14, 32'h0, 2'd1), 41, dout, en);
        wait_req(5, "tmo_req_done");
        idle(20);
        shift_dr(64'd0, 41, dout, en);
        chk("tmo_sticky", dout, dmi_word(7'h14, 32'hCAFE_0008, 2'd2));
        slv_rsp_en = 1'b1;
        wait_rsp(5, "tmo_drain_done");
        shift_ir(5'h10, iout);
        shift_dr(64'h0001_0000, 32, dout, en);
        chk("tmo_dtmcs", dout, 64'h0000_1871);
        shift_ir(5'h11, iout);
`endif

        // trst in the middle of a request drops valid without a clock edge
        slv_rdy_dly = 1000;
        slv_rsp_en  = 1'b0;
        shift_dr(dmi_word(7'h20, 32'h1, 2'd2), 41, dout, en);
        idle(3);
        chk("mid_req_vld", 64'(dmi_req_vld), 64'd1);
        @(posedge tclk);
        #2 trst = 1'b1;
        #1;
        chk("trst_req_vld", 64'(dmi_req_vld), 64'd0);
        chk("trst_rsp_rdy", 64'(dmi_rsp_rdy), 64'd0);
        #10 trst = 1'b0;
        idle(1);
        shift_dr(64'd0, 32, dout, en);
        chk("idcode_after_trst", dout, 64'h1000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtm_jtag_dmi.md
DTM_JTAG_DMI -- requirements
Module: dtm_jtag_dmi

Interface
REQ-001 SHALL take parameters, one per line:
- IR_WIDTH, 5, instruction register width (minimum 5).
- ABITS, 7, DMI address width.
- IDCODE_VAL, 32'h1000_0001, IDCODE value.
- IDLE_HINT, 1, dtmcs.idle field value.
- TIMEOUT_CYC, 255, DMI response timeout in tclk cycles.
REQ-002 SHALL have ports, one per line:
- tclk  in  1  sole clock.
- trst  in  1  reset.
- tms  in  1  TAP mode select.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out.
- tdo_en  out  1  tdo drive enable.
- dmi_req_vld  out  1  request valid.
- dmi_req_rdy  in  1  request ready.
- dmi_req_addr  out  ABITS  request address.
- dmi_req_data  out  32  write data.
- dmi_req_op  out  2  request op (1 read, 2 write).
- dmi_rsp_vld  in  1  response valid.
- dmi_rsp_rdy  out  1  response ready.
- dmi_rsp_data  in  32  read data.
- dmi_rsp_op  in  2  response status (0 ok, 2 failed, 3 busy).
REQ-003 SHALL use one clock, tclk; trst SHALL be an asynchronous, active-high reset.

Function
REQ-004 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on posedge tclk; five tms=1 clocks SHALL reach Test-Logic-Reset from any state.
REQ-005 SHALL load IR with 0x01 (IDCODE) in Test-Logic-Reset; Capture-IR SHALL load 'b01; shifting SHALL be LSB-first; IR SHALL update in Update-IR.
REQ-006 SHALL decode IR: 0x01 IDCODE (32b), 0x10 DTMCS (32b), 0x11 DMI (ABITS+34b), all other codes BYPASS (1b, captures 0).
REQ-007 SHALL capture DTMCS as {14'b0, dmihardreset=0, dmireset=0, 1'b0, IDLE_HINT[2:0], dmistat[1:0], ABITS[5:0], version=4'd1}.
REQ-008 SHALL capture DMI as {last_addr, rsp_data_hold, op}; op = sticky dmistat, or 3 if a transaction is outstanding, in which case sticky SHALL become 3.
REQ-009 On Update-DR of DMI, SHALL ignore the shifted value if sticky≠0, set sticky=3 if busy, else issue op 1/2 and treat ops 0/3 as nop.
REQ-010 SHALL run DMI FSM D_IDLE→D_REQ (req_vld=1, payload stable until req_rdy)→D_RSP (rsp_rdy=1)→D_IDLE on rsp_vld; req_vld SHALL rise on the cycle after Update-DR.
REQ-011 On response, SHALL latch rsp_data into rsp_data_hold; rsp_op 2 SHALL set sticky=2, rsp_op 3 SHALL set sticky=3, and rsp_op 0 SHALL leave sticky unchanged.
REQ-012 DTMCS Update-DR with dmireset=1 SHALL clear sticky; dmihardreset=1 SHALL clear sticky and abort: in D_REQ, req_vld drops next cycle and the FSM returns to D_IDLE; in D_RSP, the FSM goes to D_DRAIN (rsp_rdy=1, response discarded, not busy) then to D_IDLE on rsp_vld.
REQ-013 An Update-DR to DMI while in D_DRAIN SHALL set sticky=3.
REQ-014 SHALL update tdo/tdo_en on negedge tclk: tdo=shift_reg[0] and tdo_en=1 only in Shift-IR/Shift-DR; otherwise tdo=0 and tdo_en=0.

Reset
REQ-015 trst SHALL force TAP to Test-Logic-Reset, IR=0x01, DMI FSM to D_IDLE, sticky=0, shift/hold registers=0, and tdo, tdo_en, dmi_req_vld, dmi_rsp_rdy=0, asynchronously, including mid-transaction; an in-flight response is not tracked afterwards.

Configuration
REQ-016 With DTM_DMI_TIMEOUT_EN defined, D_RSP SHALL count cycles; after TIMEOUT_CYC cycles with no rsp_vld, sticky SHALL become 2 and the FSM SHALL enter D_DRAIN; without the macro, D_RSP SHALL wait indefinitely and no counter SHALL exist.

Structure
REQ-017 debug_pack SHALL hold IR codes, the DMI op and dmistat enums, the DTMCS field offsets, and the version constant.
REQ-018 The TAP FSM SHALL be sub-module dtm_tap_fsm (inputs tclk, trst, tms; outputs the state); the DMI FSM and registers SHALL stay in dtm_jtag_dmi.

Verification
REQ-019 Reset, then shift DR 32 bits at IR default -> tdo stream = IDCODE_VAL LSB-first.
REQ-020 IR=0x10, shift DR -> 0x0000_1071 (ABITS=7, IDLE_HINT=1, version=1).
REQ-021 IR=0x11, shift {addr=0x10, data=0xDEADBEEF, op=2}; slave req_rdy after 3 cycles, rsp op 0 -> req seen once with that payload; next capture op=0.
REQ-022 Read of addr 0x04 with rsp held off; capture DMI before response -> op=3; later captures op=3 until DTMCS write of 0x0001_0000 -> next capture op=0.
REQ-023 Outstanding read, then DTMCS write 0x0002_0000 -> D_DRAIN; late rsp_data 0x1234 discarded; new read then completes normally.
REQ-024 With DTM_DMI_TIMEOUT_EN, TIMEOUT_CYC=16, slave never responds -> sticky=2 at cycle 16; assert trst mid-D_REQ -> req_vld=0 immediately.
